conv_scheduler: RTL and testbench
=================================

// Module: conv_scheduler
// PURPOSE
//   Frame-level sequencer for the single-window 3x3 convolution engine.
//   - Walks the valid-window grid of an IMG_SIZE x IMG_SIZE input at a runtime stride.
//   - Hands each window origin to the engine and collects one result per window.
//   - Writes results to the output feature-map buffer.
//   - Signals done/err per frame.
// PARAMETERS
//   IMG_SIZE   7  input matrix side length
//   KER_SIZE   3  kernel side length; last legal origin LAST = IMG_SIZE-KER_SIZE
//   WIDTH_BIT  8  result data width
//   IDX_W      8  width of row/col indices; must hold IMG_SIZE
//   TIMEOUT   16  max cycles spent in WAIT before abort; must be >= 2
// PORTS
//   clock      in   1          rising-edge clock
//   reset      in   1          synchronous, active-high reset
//   start      in   1          begin a frame; honoured only in IDLE
//   stride     in   2          window step, sampled at start; 0 treated as 1
//   busy       out  1          high in every state except IDLE
//   done       out  1          one-cycle pulse at end of frame (normal or abort)
//   err        out  1          frame aborted on timeout; held until next accepted start
//   win_valid  out  1          window origin offered to engine
//   win_ready  in   1          engine accepts window this cycle
//   win_row    out  IDX_W      window origin row (multiple of stride)
//   win_col    out  IDX_W      window origin col
//   res_valid  in   1          engine result valid
//   res_data   in   WIDTH_BIT  engine result
//   out_we     out  1          output buffer write strobe
//   out_row    out  IDX_W      output element row (0,1,2,...)
//   out_col    out  IDX_W      output element col
//   out_data   out  WIDTH_BIT  value written
// BEHAVIOUR
//   - Reset: state=IDLE; all outputs 0; counters and timer 0.
//     Reset mid-frame abandons the frame: no out_we, no done.
//   - FSM: IDLE -> ISSUE -> WAIT -> WRITE -> (ISSUE | DONE) -> IDLE.
//   - IDLE
//     - start=1: latch stride (s = stride ? stride : 1), clear win/out counters, clear err -> ISSUE.
//   - ISSUE
//     - win_valid=1; win_row/win_col stable while waiting.
//     - win_ready=1: -> WAIT, timer=0.
//   - WAIT
//     - res_valid=1: capture res_data -> WRITE.
//     - Otherwise timer++. Timer reaching TIMEOUT-1 without res_valid: err=1 -> DONE.
//     - res_valid and timeout on the same cycle: res_valid wins.
//   - WRITE (1 cycle)
//     - out_we=1 with out_row/out_col/out_data = captured result.
//     - Advance the counters, then -> ISSUE, or -> DONE on the last window:
//       - win_col+s <= LAST: win_col+=s, out_col++.
//       - Else: win_col=0, out_col=0; then
//         - win_row+s <= LAST: win_row+=s, out_row++.
//         - Else: last window.
//   - DONE: done=1 for one cycle -> IDLE.
//   - Ignored inputs: start outside IDLE; win_ready outside ISSUE; res_valid outside WAIT.
//   - Throughput: 3 cycles/window minimum (win_ready and res_valid each arrive in 1st eligible cycle).
//   - Output grid side: LAST/s + 1.
//     - 7x7 input, 3x3 kernel: s=1 -> 5x5, s=2 -> 3x3, s=3 -> 2x2.
//   - Arithmetic: all index adds are unsigned at IDX_W+1 bits before the LAST compare (no wrap).
//     Timer width is $clog2(TIMEOUT+1).
// STRUCTURE
//   - conv_pkg (shared): typedef enum sched_state_t {IDLE,ISSUE,WAIT,WRITE,DONE};
//     function out_side(img,ker,s).
//   - Sub-module conv_window_counter: 2-D stride counter.
//     - Inputs: clear, step, stride.
//     - Outputs: win_row, win_col, out_row, out_col, last.
//   - FSM, timer and result register stay in conv_scheduler.
// TESTING
//   - Reset: assert reset mid-WAIT -> next cycle busy=0, done=0, out_we=0, win_valid=0;
//     no further writes.
//   - s=1, engine ready/valid immediately:
//     - 25 writes, (0,0)..(4,4) row-major.
//     - done pulses exactly once, 76 cycles after start.
//   - s=2, stride=0 (maps to 1), s=3:
//     - write counts 9, 25, 4.
//     - s=3 win origins (0,0),(0,3),(3,0),(3,3).
//   - Backpressure:
//     - win_ready low 5 cycles -> win_valid held, coords stable.
//     - res_valid delayed 7 cycles -> still written, err=0.
//   - Timeout:
//     - no res_valid after 3rd window -> done 1 pulse, err=1, exactly 2 writes.
//     - next start clears err.
//   - start pulsed while busy and res_valid in ISSUE -> ignored; write sequence unchanged.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared types and helpers for the convolution frame sequencer.
//   sched_state_t : sequencer FSM states, also exposed on the debug port.
//   out_side()    : side length of the output feature map for a given
//                   image side, kernel side and stride (stride 0 acts as 1).
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    WAIT  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } sched_state_t;

  function automatic int out_side(input int img, input int ker, input int s);
    int se;
    se = (s == 0) ? 1 : s;
    return (img - ker) / se + 1;
  endfunction

endpackage

// File: rtl/conv_scheduler_if.sv
// Engine-side and output-buffer-side bus of the convolution sequencer.
//   win_*  : window origin offered to the engine (sequencer -> engine)
//   res_*  : one result per accepted window (engine -> sequencer)
//   out_*  : write port of the output feature-map buffer (sequencer -> buffer)
//
// Handshake rules: a window transfers on a cycle where win_valid and
// win_ready are both high; while win_valid is high and win_ready low, the
// origin on win_row/win_col holds steady. res_valid has no back-pressure and
// is only looked at while a result is awaited. out_we is a single-cycle
// strobe with no acknowledge.
interface conv_scheduler_if #(
  parameter int IDX_W     = 8,
  parameter int WIDTH_BIT = 8
);
  logic                 win_valid;
  logic                 win_ready;
  logic [IDX_W-1:0]     win_row;
  logic [IDX_W-1:0]     win_col;
  logic                 res_valid;
  logic [WIDTH_BIT-1:0] res_data;
  logic                 out_we;
  logic [IDX_W-1:0]     out_row;
  logic [IDX_W-1:0]     out_col;
  logic [WIDTH_BIT-1:0] out_data;

  modport master (
    output win_valid, win_row, win_col,
    input  win_ready,
    input  res_valid, res_data,
    output out_we, out_row, out_col, out_data
  );

  modport slave (
    input  win_valid, win_row, win_col,
    output win_ready,
    output res_valid, res_data,
    input  out_we, out_row, out_col, out_data
  );
endinterface

// File: rtl/conv_window_counter.sv
// 2-D stride counter walking the valid-window grid row-major.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   clear        : restart the walk at origin (0,0)
//   step         : advance to the next window
//   stride       : step size, already mapped to a non-zero value
//   win_row/col  : current window origin in input coordinates
//   out_row/col  : matching element of the output feature map
//   last         : current window is the final one of the frame
module conv_window_counter #(
  parameter int IMG_SIZE = 7,
  parameter int KER_SIZE = 3,
  parameter int IDX_W    = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  input  logic [1:0]       stride,
  output logic [IDX_W-1:0] win_row,
  output logic [IDX_W-1:0] win_col,
  output logic [IDX_W-1:0] out_row,
  output logic [IDX_W-1:0] out_col,
  output logic             last
);

  localparam logic [IDX_W:0] LAST = (IDX_W+1)'(IMG_SIZE - KER_SIZE);

  // One extra bit so an origin near the top of the index range cannot wrap
  // back under LAST.
  logic [IDX_W:0] col_nxt;
  logic [IDX_W:0] row_nxt;
  logic           col_fits;
  logic           row_fits;

  assign col_nxt  = {1'b0, win_col} + {{(IDX_W-1){1'b0}}, stride};
  assign row_nxt  = {1'b0, win_row} + {{(IDX_W-1){1'b0}}, stride};
  assign col_fits = (col_nxt <= LAST);
  assign row_fits = (row_nxt <= LAST);
  assign last     = !col_fits && !row_fits;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      win_row <= '0;
      win_col <= '0;
      out_row <= '0;
      out_col <= '0;
    end else if (step) begin
      if (col_fits) begin
        win_col <= col_nxt[IDX_W-1:0];
        out_col <= out_col + IDX_W'(1);
      end else begin
        win_col <= '0;
        out_col <= '0;
        if (row_fits) begin
          win_row <= row_nxt[IDX_W-1:0];
          out_row <= out_row + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/conv_scheduler.sv
// Frame-level sequencer for the single-window 3x3 convolution engine.
// Walks the valid-window grid at a runtime stride, hands each origin to the
// engine, waits for its result and writes it to the output buffer.
//   clock, reset : rising-edge clock, synchronous active-high reset
//   start        : begin a frame (honoured only when idle)
//   stride       : window step, sampled at start; 0 acts as 1
//   busy         : high whenever not idle
//   done         : one-cycle pulse at the end of every frame
//   err          : frame aborted on result timeout; held until next start
//   state_dbg    : current FSM state
//   bus          : engine window/result channels and output buffer port
module conv_scheduler
  import conv_pkg::*;
#(
  parameter int IMG_SIZE  = 7,
  parameter int KER_SIZE  = 3,
  parameter int WIDTH_BIT = 8,
  parameter int IDX_W     = 8,
  parameter int TIMEOUT   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        stride,
  output logic              busy,
  output logic              done,
  output logic              err,
  output sched_state_t      state_dbg,
  conv_scheduler_if.master  bus
);

  localparam int            TW        = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

  sched_state_t         state;
  sched_state_t         state_nxt;
  logic [1:0]           s_q;
  logic [TW-1:0]        timer;
  logic [WIDTH_BIT-1:0] res_q;
  logic                 err_q;
  logic                 cnt_clear;
  logic                 cnt_step;
  logic                 cnt_last;
  logic                 accept_start;
  logic                 timed_out;
  logic [IDX_W-1:0]     win_row;
  logic [IDX_W-1:0]     win_col;
  logic [IDX_W-1:0]     out_row;
  logic [IDX_W-1:0]     out_col;

  assign accept_start = (state == IDLE) && start;
  // A result arriving on the final allowed cycle still counts.
  assign timed_out    = (state == WAIT) && !bus.res_valid && (timer == TIMER_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      s_q   <= 2'd1;
      timer <= '0;
      res_q <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept_start) begin
        s_q   <= (stride == 2'd0) ? 2'd1 : stride;
        err_q <= 1'b0;
      end
      if (state == ISSUE && bus.win_ready) begin
        timer <= '0;
      end else if (state == WAIT && !bus.res_valid && !timed_out) begin
        timer <= timer + TW'(1);
      end
      if (state == WAIT && bus.res_valid) begin
        res_q <= bus.res_data;
      end
      if (timed_out) begin
        err_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_clear = 1'b0;
    cnt_step  = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_clear = 1'b1;
          state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.win_ready) state_nxt = WAIT;
      end
      WAIT: begin
        if (bus.res_valid)  state_nxt = WRITE;
        else if (timed_out) state_nxt = DONE;
      end
      WRITE: begin
        cnt_step  = 1'b1;
        state_nxt = cnt_last ? DONE : ISSUE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  conv_window_counter #(
    .IMG_SIZE (IMG_SIZE),
    .KER_SIZE (KER_SIZE),
    .IDX_W    (IDX_W)
  ) u_cnt (
    .clock   (clock),
    .reset   (reset),
    .clear   (cnt_clear),
    .step    (cnt_step),
    .stride  (s_q),
    .win_row (win_row),
    .win_col (win_col),
    .out_row (out_row),
    .out_col (out_col),
    .last    (cnt_last)
  );

  assign busy          = (state != IDLE);
  assign done          = (state == DONE);
  assign err           = err_q;
  assign state_dbg     = state;
  assign bus.win_valid = (state == ISSUE);
  assign bus.win_row   = win_row;
  assign bus.win_col   = win_col;
  assign bus.out_we    = (state == WRITE);
  assign bus.out_row   = out_row;
  assign bus.out_col   = out_col;
  assign bus.out_data  = res_q;

endmodule

// File: tb/tb_conv_scheduler.sv
module tb_conv_scheduler;
  import conv_pkg::*;

  localparam int IDX_W = 8;
  localparam int WB    = 8;

  // ---------------- clock / reset ----------------
  logic         clock  = 1'b0;
  logic         reset  = 1'b1;
  logic         start  = 1'b0;
  logic [1:0]   stride = 2'd0;
  logic         busy;
  logic         done;
  logic         err;
  sched_state_t state_dbg;
  int           cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  conv_scheduler_if #(.IDX_W(IDX_W), .WIDTH_BIT(WB)) bus ();

  conv_scheduler #(
    .IMG_SIZE  (7),
    .KER_SIZE  (3),
    .WIDTH_BIT (WB),
    .IDX_W     (IDX_W),
    .TIMEOUT   (16)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .start     (start),
    .stride    (stride),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .state_dbg (state_dbg),
    .bus       (bus)
  );

  // Result value the engine returns for window origin (r,c).
  function automatic logic [7:0] dat(input int r, input int c);
    return 8'(r * 16 + c + 17);
  endfunction

  // ---------------- engine model ----------------
  int  ready_delay = 0;
  int  res_delay   = 0;
  int  drop_idx    = -1;
  bit  noise       = 1'b0;

  int  rcnt = 0, wcnt = 0, win_idx = 0;
  bit  pending = 1'b0, rdy_given = 1'b0, was_busy_e = 1'b0;
  logic [7:0]  cur_r = '0, cur_c = '0;
  logic [15:0] held = '0;
  logic [15:0] orig_q[$];
  int  hold_seen = 0, hold_bad = 0;

  always @(negedge clock) begin : engine
    bus.win_ready = 1'b0;
    bus.res_valid = 1'b0;
    bus.res_data  = 8'h00;
    if (busy && !was_busy_e) begin
      orig_q.delete();
      hold_seen = 0;
      hold_bad  = 0;
    end
    was_busy_e = busy;
    if (!busy) begin
      pending = 1'b0; rdy_given = 1'b0; rcnt = 0; wcnt = 0; win_idx = 0;
    end else begin
      if (rdy_given) begin
        rdy_given = 1'b0; pending = 1'b1; wcnt = 0;
      end
      if (pending) begin
        if (win_idx - 1 != drop_idx) begin
          if (wcnt == res_delay) begin
            bus.res_valid = 1'b1;
            bus.res_data  = dat(int'(cur_r), int'(cur_c));
            pending       = 1'b0;
          end else begin
            wcnt++;
          end
        end
      end else if (bus.win_valid) begin
        if (rcnt == 0) held = {bus.win_row, bus.win_col};
        else begin
          hold_seen++;
          if ({bus.win_row, bus.win_col} !== held) hold_bad++;
        end
        if (rcnt == ready_delay) begin
          bus.win_ready = 1'b1;
          rdy_given     = 1'b1;
          rcnt          = 0;
          cur_r         = bus.win_row;
          cur_c         = bus.win_col;
          orig_q.push_back({bus.win_row, bus.win_col});
          win_idx++;
        end else begin
          rcnt++;
        end
        if (noise) begin
          bus.res_valid = 1'b1;
          bus.res_data  = 8'hEE;
        end
      end
    end
  end

  // ---------------- output monitor ----------------
  logic [23:0] obs_q[$];
  int  done_cnt = 0, done_cyc = 0;
  bit  was_busy_m = 1'b0;

  always @(negedge clock) begin : monitor
    if (busy && !was_busy_m) begin
      obs_q.delete();
      done_cnt = 0;
    end
    was_busy_m = busy;
    if (bus.out_we) obs_q.push_back({bus.out_row, bus.out_col, bus.out_data});
    if (done) begin
      done_cnt++;
      if (done_cnt == 1) done_cyc = cyc;
    end
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [23:0] exp_q[$];
  int start_cyc = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic pulse_start(input logic [1:0] st);
    @(negedge clock);
    stride    = st;
    start     = 1'b1;
    start_cyc = cyc;
    @(negedge clock);
    start  = 1'b0;
    stride = 2'd3;
    @(negedge clock);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(negedge clock);
      n++;
    end
    ok = (done_cnt > 0);
    step(3);
  endtask

  task automatic check_writes(input string tag, input int s, input int side);
    exp_q.delete();
    for (int r = 0; r < side; r++)
      for (int c = 0; c < side; c++)
        exp_q.push_back({8'(r), 8'(c), dat(r * s, c * s)});
    chk({tag, "_wr_count"}, 32'(obs_q.size()), 32'(side * side));
    for (int i = 0; i < exp_q.size(); i++)
      if (i < obs_q.size()) chk({tag, "_wr"}, 32'(obs_q[i]), 32'(exp_q[i]));
  endtask

  task automatic run_frame(input logic [1:0] st, input int s, input int side, input string tag);
    bit ok;
    pulse_start(st);
    wait_done(2000, ok);
    chk({tag, "_done_seen"}, 32'(ok), 32'd1);
    chk({tag, "_done_once"}, 32'(done_cnt), 32'd1);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_idle_after"}, 32'(busy), 32'd0);
    check_writes(tag, s, side);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    bit ok;
    int n;
    int n_wr;
    logic [15:0] eo [4];
    eo[0] = 16'h0000; eo[1] = 16'h0003; eo[2] = 16'h0300; eo[3] = 16'h0303;

    // Reset state
    reset = 1'b1;
    step(3);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_done",      32'(done), 32'd0);
    chk("rst_err",       32'(err), 32'd0);
    chk("rst_win_valid", 32'(bus.win_valid), 32'd0);
    chk("rst_out_we",    32'(bus.out_we), 32'd0);
    chk("rst_win_rc",    32'({bus.win_row, bus.win_col}), 32'd0);
    chk("rst_out_rc",    32'({bus.out_row, bus.out_col}), 32'd0);
    chk("rst_out_data",  32'(bus.out_data), 32'd0);
    chk("rst_state",     32'(state_dbg), 32'(IDLE));
    reset = 1'b0;
    step(2);

    // Stride 1, engine immediate: 25 writes, done 76 cycles after start
    run_frame(2'd1, 1, 5, "s1");
    chk("s1_done_latency", 32'(done_cyc - start_cyc), 32'd76);

    // Stride 2, stride 0 (acts as 1), stride 3
    run_frame(2'd2, 2, 3, "s2");
    run_frame(2'd0, 1, 5, "s0");
    run_frame(2'd3, 3, 2, "s3");
    chk("s3_orig_count", 32'(orig_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      if (i < orig_q.size()) chk("s3_orig", 32'(orig_q[i]), 32'(eo[i]));

    // Back-pressure: win_ready held off 5 cycles, result 7 cycles late
    ready_delay = 5;
    res_delay   = 7;
    run_frame(2'd3, 3, 2, "bp");
    chk("bp_hold_cycles", 32'(hold_seen), 32'd20);
    chk("bp_hold_stable", 32'(hold_bad), 32'd0);
    ready_delay = 0;
    res_delay   = 0;

    // Timeout: third window never answered
    drop_idx = 2;
    pulse_start(2'd1);
    wait_done(300, ok);
    chk("to_done_seen", 32'(ok), 32'd1);
    chk("to_done_once", 32'(done_cnt), 32'd1);
    chk("to_err", 32'(err), 32'd1);
    chk("to_wr_count", 32'(obs_q.size()), 32'd2);
    if (obs_q.size() > 1) chk("to_wr1", 32'(obs_q[1]), 32'({8'd0, 8'd1, dat(0, 1)}));
    step(5);
    chk("to_err_held", 32'(err), 32'd1);
    chk("to_idle", 32'(busy), 32'd0);
    drop_idx = -1;

    // Next start clears err
    pulse_start(2'd3);
    chk("clr_err", 32'(err), 32'd0);
    wait_done(500, ok);
    chk("clr_done_seen", 32'(ok), 32'd1);
    check_writes("clr", 3, 2);

    // start while busy and res_valid during ISSUE are ignored
    noise       = 1'b1;
    ready_delay = 2;
    pulse_start(2'd2);
    for (int k = 0; k < 4; k++) begin
      step(3);
      start  = 1'b1;
      stride = 2'd1;
      @(negedge clock);
      start  = 1'b0;
    end
    wait_done(2000, ok);
    chk("nz_done_seen", 32'(ok), 32'd1);
    chk("nz_done_once", 32'(done_cnt), 32'd1);
    check_writes("nz", 2, 3);
    noise       = 1'b0;
    ready_delay = 0;

    // Reset in the middle of WAIT abandons the frame
    res_delay = 10;
    pulse_start(2'd1);
    n = 0;
    while (state_dbg != WAIT && n < 50) begin
      @(negedge clock);
      n++;
    end
    chk("mr_in_wait", 32'(state_dbg), 32'(WAIT));
    step(2);
    n_wr  = obs_q.size();
    reset = 1'b1;
    @(negedge clock);
    chk("mr_busy",      32'(busy), 32'd0);
    chk("mr_done",      32'(done), 32'd0);
    chk("mr_out_we",    32'(bus.out_we), 32'd0);
    chk("mr_win_valid", 32'(bus.win_valid), 32'd0);
    chk("mr_state",     32'(state_dbg), 32'(IDLE));
    reset = 1'b0;
    step(20);
    chk("mr_no_writes", 32'(obs_q.size()), 32'(n_wr));
    chk("mr_no_done",   32'(done_cnt), 32'd0);
    chk("mr_still_idle", 32'(busy), 32'd0);
    res_delay = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
